int_ctrl_vec: RTL
=================

Name: int_ctrl_vec

Overview:
- Parametrised vectored interrupt controller. Successor to the CPU's fixed 8-line `intr` input handling.
- Latches up to N_INT request lines and masks them. Selects the highest-priority enabled request.
- Presents an `irq` and a jump vector to the CPU control unit.
- Tracks in-service levels through ack/iret handshakes. Sits between the external `intr` bus and the CPU's control unit / PC-stack logic.

Parameters:
- N_INT, 8, number of interrupt lines (2..32).
- ADDR_W, 10, width of the program-address / vector output.
- VEC_BASE, 10'h3C0, vector address of line 0.
- VEC_STRIDE, 4, address distance between consecutive vectors (power of two).

Ports:
- clk  in  1  system clock, rising-edge.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- intr  in  N_INT  request lines, active-high, each held ≥1 clk cycle.
- mask_we  in  1  write strobe for the enable register.
- mask_wdata  in  N_INT  new enable value (1 = line enabled).
- mask  out  N_INT  current enable register.
- irq  out  1  interrupt request to CPU, registered.
- vector  out  ADDR_W  VEC_BASE + idx*VEC_STRIDE of the requested line; valid while irq=1.
- ack  in  1  CPU takes the interrupt (1-cycle pulse).
- iret  in  1  CPU returns from the handler (1-cycle pulse).
- pending  out  N_INT  latched requests not yet acknowledged.
- in_service  out  N_INT  lines currently being serviced.

Behaviour:
- Reset (reset=0, async), all outputs and state cleared:
  - pending, in_service, irq = 0; vector = VEC_BASE; mask = all ones; FSM = IDLE.
- Edge capture:
  - intr_d is registered each cycle.
  - pending[i] sets on intr[i] & ~intr_d[i]. Levels held for many cycles produce one request.
- Priority: lower index = higher priority.
  - cand = pending & mask.
  - best = lowest set bit of cand.
- Eligibility, without nesting: a request is eligible only when in_service == 0.
- FSM (2 states):
  - IDLE:
    - If eligible cand ≠ 0, go to REQ next cycle with irq=1 and idx=best. Latency from intr rising edge to irq = 2 cycles (edge reg + FSM reg).
  - REQ:
    - idx/vector re-evaluated every cycle to the current best eligible line.
    - If eligible cand becomes 0 (masked, no ack), go to IDLE and drop irq next cycle.
    - On ack: clear pending[idx], set in_service[idx], go to IDLE, irq=0 next cycle.
- iret: clears the highest-priority set bit of in_service. If in_service == 0, iret is ignored.
- Boundaries:
  - ack while irq=0: ignored.
  - New edge on line i in the same cycle ack clears pending[i]: set wins, pending[i] stays 1.
  - ack and iret in the same cycle: iret is applied to in_service before the ack bit is set.
  - mask_we takes effect next cycle. Masking a line does not clear its pending bit.
  - vector width: idx*VEC_STRIDE is truncated to ADDR_W bits (wrap-around permitted, not flagged).
  - Async reset mid-REQ: irq drops immediately and pending requests are lost.

Optional Feature:
- Macro INT_NESTED_EN.
- Defined:
  - Eligibility = cand restricted to lines of strictly higher priority than the highest-priority bit set in in_service (any line if in_service == 0).
  - A higher-priority request preempts the running handler (irq rises while in_service ≠ 0).
  - in_service can hold multiple bits; iret unwinds one level per pulse, highest priority first.
- Undefined: no preemption. irq held off until in_service == 0.

Test Plan:
- Single request, no mask:
  - Stimulus: reset released; intr=8'h01 for 1 cycle.
  - Required: pending=01 next cycle; irq=1 and vector=10'h3C0 two cycles after the edge.
  - Stimulus: ack.
  - Required: pending=00, in_service=01, irq=0. After iret, in_service=00.
- Simultaneous lines:
  - Stimulus: intr=8'b10100010.
  - Required: vector=VEC_BASE+4 (line 1). After ack/iret, irq again with vector=VEC_BASE+20 (line 5). After ack/iret, vector=VEC_BASE+28 (line 7).
- Masking:
  - Stimulus: mask_wdata=8'hFE; intr[0] pulse.
  - Required: pending=01, irq stays 0. Writing mask=FF raises irq with vector=10'h3C0.
- Set-wins collision:
  - Stimulus: intr[3] second rising edge in the cycle of ack for line 3.
  - Required: pending[3]=1, in_service[3]=1 afterwards.
- Preemption:
  - Stimulus: line 4 in service; intr[2] pulse.
  - Required with INT_NESTED_EN: irq=1, vector=VEC_BASE+8; after ack, in_service=8'h14; one iret gives 8'h10.
  - Required without the macro: irq=0 until iret clears in_service, then vector=VEC_BASE+8.
- Reset mid-operation:
  - Stimulus: reset=0 asynchronously while irq=1 and pending=8'h22.
  - Required: irq, pending, in_service = 0 immediately; mask=FF.

Source files
------------

// File: rtl/int_ctrl_vec.sv
`default_nettype none
// ============================================================================
// Module   : int_ctrl_vec
// Purpose  : Vectored interrupt controller. Edge-captured request lines,
//            enable mask, fixed priority (line 0 highest), ack/iret tracking.
//            Define INT_NESTED_EN to allow higher-priority preemption.
// Revision : 1.0 - initial release
// ============================================================================
module int_ctrl_vec #(
  parameter int unsigned        N_INT      = 8,
  parameter int unsigned        ADDR_W     = 10,
  parameter logic [ADDR_W-1:0]  VEC_BASE   = ADDR_W'(10'h3C0),
  parameter int unsigned        VEC_STRIDE = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N_INT-1:0]  intr,
  input  logic              mask_we,
  input  logic [N_INT-1:0]  mask_wdata,
  output logic [N_INT-1:0]  mask,
  output logic              irq,
  output logic [ADDR_W-1:0] vector,
  input  logic              ack,
  input  logic              iret,
  output logic [N_INT-1:0]  pending,
  output logic [N_INT-1:0]  in_service
);

  localparam int unsigned IDX_W     = (N_INT > 1) ? $clog2(N_INT) : 1;
  localparam int unsigned STRIDE_SH = $clog2(VEC_STRIDE);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_REQ  = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [N_INT-1:0] intr_d_q, intr_d_d;
  logic [N_INT-1:0] pending_q, pending_d;
  logic [N_INT-1:0] in_service_q, in_service_d;
  logic [N_INT-1:0] mask_q, mask_d;
  logic [IDX_W-1:0] idx_q, idx_d;

  logic [N_INT-1:0] rise;
  logic [N_INT-1:0] cand;
  logic [N_INT-1:0] allow;
  logic [N_INT-1:0] elig;
  logic             elig_any;
  logic [IDX_W-1:0] best;
  logic             ack_take;
  logic [N_INT-1:0] ack_clr;
  logic [N_INT-1:0] iret_left;
  logic [ADDR_W-1:0] vec_off;

  assign rise = intr & ~intr_d_q;
  assign cand = pending_q & mask_q;

`ifdef INT_NESTED_EN
  logic blocked;

  // A line is allowed only if every in-service line has lower priority.
  always_comb begin
    allow   = '0;
    blocked = 1'b0;
    for (int i = 0; i < N_INT; i++) begin
      blocked  = blocked | in_service_q[i];
      allow[i] = ~blocked;
    end
  end
`else
  always_comb begin
    allow = (in_service_q == '0) ? '1 : '0;
  end
`endif

  assign elig     = cand & allow;
  assign elig_any = |elig;

  always_comb begin
    best = '0;
    for (int i = N_INT - 1; i >= 0; i--) begin
      if (elig[i]) begin
        best = IDX_W'(i);
      end
    end
  end

  // FSM: state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (elig_any) begin
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        if (ack || !elig_any) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    irq      = (state_q == S_REQ);
    ack_take = ack & (state_q == S_REQ);
  end

  always_comb begin
    intr_d_d = intr;
    idx_d    = (state_d == S_REQ) ? best : idx_q;
    mask_d   = mask_we ? mask_wdata : mask_q;
    ack_clr  = ack_take ? (N_INT'(1) << idx_q) : '0;

    // A fresh edge in the same cycle as the ack clear keeps the request.
    pending_d = (pending_q & ~ack_clr) | rise;

    // iret retires the highest-priority level before the new ack bit lands.
    iret_left = in_service_q;
    if (iret && (in_service_q != '0)) begin
      iret_left = in_service_q & (in_service_q - N_INT'(1));
    end
    in_service_d = iret_left | ack_clr;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      intr_d_q     <= '0;
      pending_q    <= '0;
      in_service_q <= '0;
      mask_q       <= '1;
      idx_q        <= '0;
    end else begin
      intr_d_q     <= intr_d_d;
      pending_q    <= pending_d;
      in_service_q <= in_service_d;
      mask_q       <= mask_d;
      idx_q        <= idx_d;
    end
  end

  // Offset wraps silently inside ADDR_W bits.
  assign vec_off    = ADDR_W'(idx_q) << STRIDE_SH;
  assign vector     = VEC_BASE + vec_off;
  assign mask       = mask_q;
  assign pending    = pending_q;
  assign in_service = in_service_q;

endmodule
`default_nettype wire
